// File: rtl/prog_sequencer_if.sv
// Host-side bus of prog_sequencer: instruction-memory load port, start/length request,
// and the register-file / ALU control outputs driven while a program runs.
interface prog_sequencer_if #(
   parameter int IMEM_DEPTH = 16,
   parameter int INSTR_W    = 8
);
   localparam int PC_W = $clog2(IMEM_DEPTH);

   logic               load_valid;
   logic               load_ready;
   logic [PC_W-1:0]    load_addr;
   logic [INSTR_W-1:0] load_data;
   logic               start;
   logic [PC_W:0]      prog_len;
   logic               busy;
   logic               done;
   logic [PC_W-1:0]    pc;
   logic [1:0]         alu_op;
   logic [1:0]         read_reg1;
   logic [1:0]         read_reg2;
   logic [1:0]         write_reg;
   logic               reg_write;

   modport master (
      output load_valid, load_addr, load_data, start, prog_len,
      input  load_ready, busy, done, pc, alu_op, read_reg1, read_reg2, write_reg, reg_write
   );

   modport slave (
      input  load_valid, load_addr, load_data, start, prog_len,
      output load_ready, busy, done, pc, alu_op, read_reg1, read_reg2, write_reg, reg_write
   );
endinterface

// File: rtl/prog_sequencer.sv
// Program sequencer: loads a small instruction memory, then steps FETCH/DECODE/EXEC/WB per instruction.
// Optional SEQ_SINGLE_STEP_EN adds a step input and a PAUSE state after every non-final write-back.
module prog_sequencer #(
   parameter int IMEM_DEPTH = 16,
   parameter int INSTR_W    = 8
) (
   input logic clk_i,
   input logic reset_i,
`ifdef SEQ_SINGLE_STEP_EN
   input logic step_i,
`endif
   prog_sequencer_if.slave bus
);
   localparam int PC_W  = $clog2(IMEM_DEPTH);
   localparam int LEN_W = PC_W + 1;
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IMEM_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      WB,
      DONE
`ifdef SEQ_SINGLE_STEP_EN
      , PAUSE
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic [1:0]         aluOp_q, aluOp_d;
   logic [1:0]         readReg1_q, readReg1_d;
   logic [1:0]         readReg2_q, readReg2_d;
   logic [1:0]         writeReg_q, writeReg_d;

   logic [INSTR_W-1:0] imem [IMEM_DEPTH];
   logic [LEN_W-1:0]   clampedLen;
   logic               lastInstr;

   assign clampedLen = (bus.prog_len > MAX_LEN) ? MAX_LEN : bus.prog_len;
   assign lastInstr  = ({1'b0, pc_q} + LEN_W'(1)) == len_q;

   // Instruction memory survives reset so a program can be rerun after an abort.
   always_ff @(posedge clk_i) begin
      if (bus.load_valid && (state_q == IDLE)) begin
         imem[bus.load_addr] <= bus.load_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      len_d      = len_q;
      ir_d       = ir_q;
      aluOp_d    = aluOp_q;
      readReg1_d = readReg1_q;
      readReg2_d = readReg2_q;
      writeReg_d = writeReg_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               len_d   = clampedLen;
               pc_d    = '0;
               state_d = (clampedLen == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            ir_d    = imem[pc_q];
            state_d = DECODE;
         end
         DECODE: begin
            aluOp_d    = ir_q[7:6];
            writeReg_d = ir_q[5:4];
            readReg1_d = ir_q[3:2];
            readReg2_d = ir_q[1:0];
            state_d    = EXEC;
         end
         EXEC: state_d = WB;
         WB: begin
            if (lastInstr) begin
               state_d = DONE;
            end else begin
`ifdef SEQ_SINGLE_STEP_EN
               state_d = PAUSE;
`else
               pc_d    = pc_q + PC_W'(1);
               state_d = FETCH;
`endif
            end
         end
`ifdef SEQ_SINGLE_STEP_EN
         PAUSE: begin
            if (step_i) begin
               pc_d    = pc_q + PC_W'(1);
               state_d = FETCH;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         len_q      <= '0;
         ir_q       <= '0;
         aluOp_q    <= '0;
         readReg1_q <= '0;
         readReg2_q <= '0;
         writeReg_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         len_q      <= len_d;
         ir_q       <= ir_d;
         aluOp_q    <= aluOp_d;
         readReg1_q <= readReg1_d;
         readReg2_q <= readReg2_d;
         writeReg_q <= writeReg_d;
      end
   end

   // Status strobes decode straight from state so an async reset drops them at once.
   assign bus.load_ready = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE) && (state_q != DONE);
   assign bus.done       = (state_q == DONE);
   assign bus.reg_write  = (state_q == WB);
   assign bus.pc         = pc_q;
   assign bus.alu_op     = aluOp_q;
   assign bus.read_reg1  = readReg1_q;
   assign bus.read_reg2  = readReg2_q;
   assign bus.write_reg  = writeReg_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: table of single-instruction programs, random programs
// against a timing/trace model, plus hand-written busy, reset and (with SEQ_SINGLE_STEP_EN) step sequences.
`timescale 1ns/1ps
module tb_prog_sequencer;
   localparam int DEPTH = 16;
`ifdef SEQ_SINGLE_STEP_EN
   localparam int PER = 5;
`else
   localparam int PER = 4;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
   logic step = 1'b1;
`endif

   prog_sequencer_if #(.IMEM_DEPTH(DEPTH), .INSTR_W(8)) bus ();

   prog_sequencer #(.IMEM_DEPTH(DEPTH), .INSTR_W(8)) dut (
      .clk_i   (clk),
      .reset_i (reset),
`ifdef SEQ_SINGLE_STEP_EN
      .step_i  (step),
`endif
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] instr;
      logic [1:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
   } vec_t;

   typedef struct {
      int         off;
      int         pc;
      logic [1:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
   } wr_t;

   int         nCompared = 0;
   int         nMismatched = 0;
   logic [7:0] tbImem [DEPTH];
   wr_t        seen [$];
   vec_t       vecs [4];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Writes one instruction word while idle; called and returns at a falling edge.
   task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data);
      checkOutput("load_ready idle", 32'(bus.load_ready), 1);
      bus.load_valid = 1'b1;
      bus.load_addr  = addr;
      bus.load_data  = data;
      @(negedge clk);
      bus.load_valid = 1'b0;
      tbImem[addr]   = data;
   endtask

   // Model: instruction i writes back at offset PER*i+4 with fields of tbImem[i];
   // done one cycle after the last write-back (offset 1 for an empty program).
   task automatic runProgram(input int len, input bit interfere, input string tag);
      int         expL;
      int         doneOff;
      int         doneCount;
      int         busyCount;
      int         budget;
      logic [7:0] w;
      wr_t        r;
      expL      = (len > DEPTH) ? DEPTH : len;
      doneOff   = -1;
      doneCount = 0;
      busyCount = 0;
      budget    = PER * expL + 8;
      seen.delete();
      bus.prog_len = 5'(len);
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int off = 1; off <= budget; off++) begin
         if (interfere && off == 2) begin
            bus.start      = 1'b1;
            bus.prog_len   = 5'd1;
            bus.load_valid = 1'b1;
            bus.load_addr  = 4'd0;
            bus.load_data  = ~tbImem[0];
            checkOutput({tag, " load_ready busy"}, 32'(bus.load_ready), 0);
         end
         if (interfere && off == 6) begin
            bus.start      = 1'b0;
            bus.load_valid = 1'b0;
         end
         if (bus.reg_write === 1'b1) begin
            r.off = off;
            r.pc  = int'(bus.pc);
            r.op  = bus.alu_op;
            r.rd  = bus.write_reg;
            r.rs1 = bus.read_reg1;
            r.rs2 = bus.read_reg2;
            seen.push_back(r);
         end
         if (bus.done === 1'b1) begin
            doneCount++;
            if (doneOff < 0) doneOff = off;
         end
         if (bus.busy === 1'b1) busyCount++;
         @(negedge clk);
      end
      checkOutput({tag, " write count"}, 32'(seen.size()), 32'(expL));
      for (int i = 0; i < seen.size() && i < expL; i++) begin
         w = tbImem[i];
         checkOutput($sformatf("%s wr%0d offset", tag, i), 32'(seen[i].off), 32'(PER * i + 4));
         checkOutput($sformatf("%s wr%0d pc", tag, i), 32'(seen[i].pc), 32'(i));
         checkOutput($sformatf("%s wr%0d alu_op", tag, i), 32'(seen[i].op), 32'(w[7:6]));
         checkOutput($sformatf("%s wr%0d write_reg", tag, i), 32'(seen[i].rd), 32'(w[5:4]));
         checkOutput($sformatf("%s wr%0d read_reg1", tag, i), 32'(seen[i].rs1), 32'(w[3:2]));
         checkOutput($sformatf("%s wr%0d read_reg2", tag, i), 32'(seen[i].rs2), 32'(w[1:0]));
      end
      checkOutput({tag, " done offset"}, 32'(doneOff), (expL == 0) ? 32'd1 : 32'(PER * (expL - 1) + 5));
      checkOutput({tag, " done pulses"}, 32'(doneCount), 1);
      checkOutput({tag, " busy cycles"}, 32'(busyCount), (expL == 0) ? 32'd0 : 32'(PER * (expL - 1) + 4));
      if (expL > 0) begin
         w = tbImem[expL - 1];
         checkOutput({tag, " hold alu_op"}, 32'(bus.alu_op), 32'(w[7:6]));
         checkOutput({tag, " hold write_reg"}, 32'(bus.write_reg), 32'(w[5:4]));
      end
      checkOutput({tag, " load_ready after"}, 32'(bus.load_ready), 1);
   endtask

   initial begin
      bus.load_valid = 1'b0;
      bus.load_addr  = '0;
      bus.load_data  = '0;
      bus.start      = 1'b0;
      bus.prog_len   = '0;
      for (int i = 0; i < DEPTH; i++) tbImem[i] = 8'h00;

      vecs[0] = '{8'b01_10_00_01, 2'd1, 2'd2, 2'd0, 2'd1};
      vecs[1] = '{8'b11_01_10_11, 2'd3, 2'd1, 2'd2, 2'd3};
      vecs[2] = '{8'b00_11_11_00, 2'd0, 2'd3, 2'd3, 2'd0};
      vecs[3] = '{8'b10_00_01_10, 2'd2, 2'd0, 2'd1, 2'd2};

      #3;
      checkOutput("reset reg_write", 32'(bus.reg_write), 0);
      checkOutput("reset busy", 32'(bus.busy), 0);
      checkOutput("reset done", 32'(bus.done), 0);
      checkOutput("reset load_ready", 32'(bus.load_ready), 1);
      checkOutput("reset pc", 32'(bus.pc), 0);
      checkOutput("reset alu_op", 32'(bus.alu_op), 0);
      checkOutput("reset read_reg1", 32'(bus.read_reg1), 0);
      checkOutput("reset read_reg2", 32'(bus.read_reg2), 0);
      checkOutput("reset write_reg", 32'(bus.write_reg), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         applyStimulus(4'd0, vecs[v].instr);
         runProgram(1, 1'b0, $sformatf("vec%0d", v));
         if (seen.size() > 0) begin
            checkOutput($sformatf("vec%0d table alu_op", v), 32'(seen[0].op), 32'(vecs[v].op));
            checkOutput($sformatf("vec%0d table write_reg", v), 32'(seen[0].rd), 32'(vecs[v].rd));
            checkOutput($sformatf("vec%0d table read_reg1", v), 32'(seen[0].rs1), 32'(vecs[v].rs1));
            checkOutput($sformatf("vec%0d table read_reg2", v), 32'(seen[0].rs2), 32'(vecs[v].rs2));
         end
      end

      applyStimulus(4'd0, 8'b00_01_10_11);
      applyStimulus(4'd1, 8'b01_10_11_00);
      applyStimulus(4'd2, 8'b10_11_00_01);
      runProgram(3, 1'b0, "three");
      runProgram(0, 1'b0, "empty");

      for (int i = 0; i < DEPTH; i++) applyStimulus(4'(i), 8'($urandom));
      runProgram(20, 1'b0, "clamp20");

      runProgram(3, 1'b1, "busy-ignore");
      runProgram(3, 1'b0, "imem-intact");

      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 4; i++) applyStimulus(4'($urandom_range(0, DEPTH - 1)), 8'($urandom));
         runProgram(int'($urandom_range(0, 20)), 1'b0, $sformatf("rand%0d", t));
      end

      // Abort during EXEC of the second instruction, then rerun from a clean IDLE.
      bus.prog_len = 5'd3;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (PER + 2) @(negedge clk);
      checkOutput("pre-reset busy", 32'(bus.busy), 1);
      checkOutput("pre-reset pc", 32'(bus.pc), 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort reg_write", 32'(bus.reg_write), 0);
      checkOutput("abort busy", 32'(bus.busy), 0);
      checkOutput("abort done", 32'(bus.done), 0);
      checkOutput("abort load_ready", 32'(bus.load_ready), 1);
      checkOutput("abort pc", 32'(bus.pc), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      runProgram(3, 1'b0, "rerun");

`ifdef SEQ_SINGLE_STEP_EN
      step = 1'b0;
      applyStimulus(4'd0, 8'b01_10_00_01);
      applyStimulus(4'd1, 8'b11_01_10_11);
      bus.prog_len = 5'd2;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("step wb1 reg_write", 32'(bus.reg_write), 1);
      repeat (6) begin
         @(negedge clk);
         checkOutput("step pause reg_write", 32'(bus.reg_write), 0);
         checkOutput("step pause busy", 32'(bus.busy), 1);
         checkOutput("step pause pc", 32'(bus.pc), 0);
      end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("step wb2 reg_write", 32'(bus.reg_write), 1);
      checkOutput("step wb2 pc", 32'(bus.pc), 1);
      checkOutput("step wb2 write_reg", 32'(bus.write_reg), 1);
      @(negedge clk);
      checkOutput("step done", 32'(bus.done), 1);
      step = 1'b1;
      @(negedge clk);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Multi-cycle program sequencer that replaces the fixed control unit in front of the 4×4-bit register file and 2-bit-opcode ALU. Holds a small instruction memory loaded through a valid/ready port, then, on a start handshake, steps a program counter through a FETCH/DECODE/EXEC/WB state machine. For each instruction it drives the register-file read/write addresses, the ALU opcode and a single-cycle write enable. Signals completion with a one-cycle done pulse.

## Interface
- IMEM_DEPTH, 16, instruction memory entries (power of two; PC width = log2)
- INSTR_W, 8, instruction width; format [7:6] alu_op, [5:4] rd, [3:2] rs1, [1:0] rs2
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- load_valid  in  1  instruction write request
- load_ready  out  1  high only in IDLE; write occurs when load_valid && load_ready
- load_addr  in  4  instruction memory address
- load_data  in  8  instruction word
- start  in  1  begin execution; sampled only in IDLE
- prog_len  in  5  instruction count, latched on accepted start; 0..16, values >16 clamp to 16
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse when the program completes
- pc  out  4  current program counter
- alu_op  out  2  ALU opcode for the current instruction
- read_reg1, read_reg2  out  2  register-file read addresses (rs1, rs2)
- write_reg  out  2  register-file write address (rd)
- reg_write  out  1  register-file write enable, one cycle per instruction
- step  in  1  single-step advance (present only with SEQ_SINGLE_STEP_EN)

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, DONE (plus PAUSE when configured).
- IDLE:
  - load_ready=1.
  - On start with latched length 0 -> DONE.
  - On start with length ≥1: pc<=0, go to FETCH.
- FETCH: ir <= imem[pc] -> DECODE.
- DECODE: alu_op/read_reg1/read_reg2/write_reg registered from ir -> EXEC.
- EXEC: register-file and ALU settle combinationally; outputs held -> WB.
- WB:
  - reg_write=1 for exactly this cycle; result is written at the end of WB.
  - If pc+1 == length -> DONE; else pc<=pc+1, go to FETCH.
- DONE: done=1 for one cycle -> IDLE.
- Address/opcode outputs hold the last instruction's values after completion. reg_write is 0 in every state except WB.
- start while busy is ignored. load_valid outside IDLE is not accepted (load_ready=0).
- Load and start in the same IDLE cycle: the write is performed and start is accepted. The first FETCH is ≥1 cycle later, so the new word is visible.
- The instruction memory is not cleared by reset.
- Reset mid-program (asynchronous):
  - Immediately: state=IDLE, reg_write=0, busy=0, done=0.
  - The partially executed instruction is abandoned.

## Timing
- Reset values:
  - pc=0, ir=0, alu_op=0, read_reg1=0, read_reg2=0, write_reg=0.
  - reg_write=0, busy=0, done=0, load_ready=1.
- Start accepted at edge N: FETCH in cycle N+1, first reg_write in cycle N+4.
- Each instruction takes 4 cycles. A program of L instructions has its final WB at cycle N+4L and done at N+4L+1.
- prog_len=0: done at cycle N+1, no reg_write.
- Read-after-write on the same register needs no forwarding: the next DECODE is ≥2 cycles after the write edge.
- pc wraps are impossible: completion always precedes pc reaching length.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - Adds the step input and a PAUSE state.
  - WB transitions to PAUSE instead of FETCH (still to DONE after the last instruction).
  - PAUSE holds all outputs with reg_write=0 and busy=1.
  - On step=1, PAUSE sets pc<=pc+1 and goes to FETCH.
- SEQ_SINGLE_STEP_EN undefined: no step port and no PAUSE state; execution is free-running as above.

## Test plan
- Load imem[0]=8'b01_10_00_01, start, prog_len=1 -> reg_write high exactly in cycle N+4 with write_reg=2, read_reg1=0, read_reg2=1, alu_op=1; done at N+5.
- Load 3 instructions, start, prog_len=3 -> exactly 3 reg_write pulses spaced 4 cycles apart; pc sequence 0,1,2; done at N+13; busy high N+1..N+12.
- start with prog_len=0 -> done at N+1, no reg_write; start with prog_len=20 -> exactly 16 instructions execute.
- Assert load_valid and start while busy -> load_ready=0, imem unchanged, second start ignored, done pulses once.
- Assert reset during EXEC of instruction 2 -> reg_write=0 and busy=0 immediately; a rerun from IDLE executes from pc=0 with the imem contents intact.
- SEQ_SINGLE_STEP_EN: 2-instruction program -> waits in PAUSE after the first WB until step; second reg_write occurs 4 cycles after the step pulse.
